// File: rtl/fv_core_if_mode_ctrl_if.sv
// Purpose : bundles the IF-stage control inputs and mode/status outputs of the
//           duplicate-instruction mode controller into one port.
// Ports   : master drives the control strobes and observes the status; slave
//           (the controller) is the reverse. occupancy width follows QDEPTH.
interface fv_core_if_mode_ctrl_if #(
  parameter int QDEPTH = 16
);
  localparam int OW = $clog2(QDEPTH + 1);

  // control strobes into the controller
  logic          enable;
  logic          dup_enable_req;
  logic          queue_push;
  logic          queue_pop;
  logic          fv_if_attempt_dup;
  logic          goto_passthru_mode;
  logic          passthru_done;

  // mode and status out of the controller
  logic          dup_enable;
  logic          in_dup_mode;
  logic          in_passthru_mode;
  logic          is_empty;
  logic          is_full;
  logic [OW-1:0] occupancy;
  logic [3:0]    err_cause;
  logic          mode_err;

  modport master (
    output enable, dup_enable_req, queue_push, queue_pop,
           fv_if_attempt_dup, goto_passthru_mode, passthru_done,
    input  dup_enable, in_dup_mode, in_passthru_mode, is_empty, is_full,
           occupancy, err_cause, mode_err
  );

  modport slave (
    input  enable, dup_enable_req, queue_push, queue_pop,
           fv_if_attempt_dup, goto_passthru_mode, passthru_done,
    output dup_enable, in_dup_mode, in_passthru_mode, is_empty, is_full,
           occupancy, err_cause, mode_err
  );
endinterface

// File: rtl/fv_core_if_mode_ctrl.sv
// Purpose : IF-stage mode controller for instruction duplication: tracks the
//           original/duplicate/passthru phases and duplicate-queue occupancy.
// Latency : all mode/status outputs are registered, updating one edge after
//           the causing event; mode_err is a combinational OR of err_cause.
// Backpres: none applied; enable=0 freezes the FSM and occupancy (PASSTHRU
//           still watches passthru_done and its timeout). Illegal strobes are
//           flagged in sticky err_cause instead of being stalled.
// Ports   : clk, rst_n (async active-low); bus = slave side of
//           fv_core_if_mode_ctrl_if carrying strobes in and status out.
module fv_core_if_mode_ctrl #(
  parameter int QDEPTH     = 16,
  parameter int PT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fv_core_if_mode_ctrl_if.slave bus
);

  localparam int OW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(PT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ORIG     = 2'd1,
    S_DUP      = 2'd2,
    S_PASSTHRU = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          dup_en_q, dup_en_d;
  logic [3:0]    err_q, err_d;
  logic [PW-1:0] pt_cnt_q, pt_cnt_d;

  logic empty, full, any_op, legal_pop;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OW'(QDEPTH));
  assign any_op    = bus.queue_push | bus.queue_pop;
  assign legal_pop = bus.enable && (state_q == S_DUP) && bus.queue_pop &&
                     !bus.queue_push && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      occ_q    <= '0;
      dup_en_q <= 1'b0;
      err_q    <= '0;
      pt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      dup_en_q <= dup_en_d;
      err_q    <= err_d;
      pt_cnt_q <= pt_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    dup_en_d = dup_en_q;
    err_d    = err_q;
    pt_cnt_d = pt_cnt_q;

    // Queue bookkeeping. Only a lone push in ORIG or a lone pop in DUP is a
    // legal operation; anything else is flagged and leaves occupancy alone.
    if (bus.enable && any_op) begin
      if (bus.queue_push && bus.queue_pop) begin
        err_d[2] = 1'b1;
      end else if (state_q == S_ORIG && bus.queue_push) begin
        if (full) err_d[0] = 1'b1;
        else      occ_d = occ_q + OW'(1);
      end else if (state_q == S_DUP && bus.queue_pop) begin
        if (empty) err_d[1] = 1'b1;
        else       occ_d = occ_q - OW'(1);
      end else begin
        err_d[2] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable && bus.dup_enable_req) begin
          state_d  = S_ORIG;
          dup_en_d = 1'b1;
        end
      end
      S_ORIG: begin
        // A flush/taken-CF send outranks starting duplicates or shutting down.
        if (bus.enable) begin
          if (any_op && bus.goto_passthru_mode) begin
            state_d  = S_PASSTHRU;
            pt_cnt_d = '0;
          end else if (bus.fv_if_attempt_dup && !empty) begin
            state_d = S_DUP;
          end else if (!bus.dup_enable_req && empty && !bus.queue_push) begin
            state_d  = S_IDLE;
            dup_en_d = 1'b0;
          end
        end
      end
      S_DUP: begin
        if (bus.enable) begin
          if (any_op && bus.goto_passthru_mode) begin
            state_d  = S_PASSTHRU;
            pt_cnt_d = '0;
          end else if (legal_pop && occ_q == OW'(1)) begin
            state_d = S_ORIG;
          end
        end
      end
      S_PASSTHRU: begin
        // Runs regardless of enable so a stalled IF stage cannot hide a
        // downstream resolution that never arrives.
        if (bus.passthru_done) begin
          state_d = empty ? S_ORIG : S_DUP;
        end else begin
          if (pt_cnt_q != PW'(PT_TIMEOUT)) pt_cnt_d = pt_cnt_q + PW'(1);
          if (pt_cnt_d == PW'(PT_TIMEOUT)) err_d[3] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dup_enable       = dup_en_q;
  assign bus.in_dup_mode      = (state_q == S_DUP);
  assign bus.in_passthru_mode = (state_q == S_PASSTHRU);
  assign bus.is_empty         = empty;
  assign bus.is_full          = full;
  assign bus.occupancy        = occ_q;
  assign bus.err_cause        = err_q;
  assign bus.mode_err         = |err_q;

endmodule

// File: tb/tb_fv_core_if_mode_ctrl.sv
// Purpose : directed self-checking bench for fv_core_if_mode_ctrl.
// Ports   : none; drives the master side of the interface, samples 1 ns
//           after each rising edge.
module tb_fv_core_if_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  fv_core_if_mode_ctrl_if #(.QDEPTH(16)) bus_i ();

  fv_core_if_mode_ctrl #(.QDEPTH(16), .PT_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus_i.enable             = 1'b0;
    bus_i.dup_enable_req     = 1'b0;
    bus_i.queue_push         = 1'b0;
    bus_i.queue_pop          = 1'b0;
    bus_i.fv_if_attempt_dup  = 1'b0;
    bus_i.goto_passthru_mode = 1'b0;
    bus_i.passthru_done      = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
  endtask

  // Reset -> ORIG, then n pushes, then attempt_dup to reach DUP with occ=n.
  task automatic to_dup(input int n);
    do_reset();
    bus_i.enable = 1'b1;
    bus_i.dup_enable_req = 1'b1;
    tick();
    bus_i.queue_push = 1'b1;
    repeat (n) tick();
    bus_i.queue_push = 1'b0;
    bus_i.fv_if_attempt_dup = 1'b1;
    tick();
    bus_i.fv_if_attempt_dup = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dup_en"}, 32'(bus_i.dup_enable), 32'd0);
    chk({tag, "_in_dup"}, 32'(bus_i.in_dup_mode), 32'd0);
    chk({tag, "_in_pt"},  32'(bus_i.in_passthru_mode), 32'd0);
    chk({tag, "_occ"},    32'(bus_i.occupancy), 32'd0);
    chk({tag, "_empty"},  32'(bus_i.is_empty), 32'd1);
    chk({tag, "_full"},   32'(bus_i.is_full), 32'd0);
    chk({tag, "_err"},    32'(bus_i.err_cause), 32'd0);
    chk({tag, "_merr"},   32'(bus_i.mode_err), 32'd0);
  endtask

  initial begin
    // ---- basic flow: IDLE, ORIG, DUP, ORIG
    clr();
    #3;
    chk_reset_vals("rst");
    do_reset();
    tick();
    chk("idle_hold", 32'(bus_i.dup_enable), 32'd0);
    bus_i.enable = 1'b1;
    bus_i.dup_enable_req = 1'b1;
    tick();
    chk("orig_dup_en", 32'(bus_i.dup_enable), 32'd1);
    chk("orig_in_dup", 32'(bus_i.in_dup_mode), 32'd0);
    chk("orig_occ0", 32'(bus_i.occupancy), 32'd0);
    bus_i.queue_push = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("push_occ%0d", i), 32'(bus_i.occupancy), 32'(i));
    end
    bus_i.queue_push = 1'b0;
    bus_i.fv_if_attempt_dup = 1'b1;
    tick();
    bus_i.fv_if_attempt_dup = 1'b0;
    chk("dup_entry", 32'(bus_i.in_dup_mode), 32'd1);
    chk("dup_occ3", 32'(bus_i.occupancy), 32'd3);
    bus_i.queue_pop = 1'b1;
    tick();
    chk("pop_occ2", 32'(bus_i.occupancy), 32'd2);
    chk("pop_in_dup2", 32'(bus_i.in_dup_mode), 32'd1);
    tick();
    chk("pop_occ1", 32'(bus_i.occupancy), 32'd1);
    tick();
    bus_i.queue_pop = 1'b0;
    chk("pop_occ0", 32'(bus_i.occupancy), 32'd0);
    chk("back_orig", 32'(bus_i.in_dup_mode), 32'd0);
    chk("back_orig_dup_en", 32'(bus_i.dup_enable), 32'd1);
    chk("flow_err", 32'(bus_i.err_cause), 32'd0);
    bus_i.dup_enable_req = 1'b0;
    tick();
    chk("to_idle_dup_en", 32'(bus_i.dup_enable), 32'd0);

    // ---- overflow: 17 pushes into a 16-deep queue
    do_reset();
    bus_i.enable = 1'b1;
    bus_i.dup_enable_req = 1'b1;
    tick();
    bus_i.queue_push = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("fill_occ%0d", i), 32'(bus_i.occupancy), 32'(i));
      if (i == 15) chk("full_at15", 32'(bus_i.is_full), 32'd0);
    end
    chk("full_at16", 32'(bus_i.is_full), 32'd1);
    chk("err_before_ovf", 32'(bus_i.err_cause), 32'd0);
    tick();
    bus_i.queue_push = 1'b0;
    chk("ovf_err", 32'(bus_i.err_cause), 32'b0001);
    chk("ovf_occ", 32'(bus_i.occupancy), 32'd16);
    chk("ovf_merr", 32'(bus_i.mode_err), 32'd1);

    // ---- pop into PASSTHRU, resolve 5 cycles later (enable low meanwhile)
    to_dup(2);
    chk("pt_pre_occ", 32'(bus_i.occupancy), 32'd2);
    bus_i.queue_pop = 1'b1;
    bus_i.goto_passthru_mode = 1'b1;
    tick();
    clr();
    bus_i.dup_enable_req = 1'b1;
    chk("pt_entry", 32'(bus_i.in_passthru_mode), 32'd1);
    chk("pt_not_dup", 32'(bus_i.in_dup_mode), 32'd0);
    chk("pt_occ1", 32'(bus_i.occupancy), 32'd1);
    repeat (4) tick();
    chk("pt_hold", 32'(bus_i.in_passthru_mode), 32'd1);
    bus_i.passthru_done = 1'b1;
    tick();
    bus_i.passthru_done = 1'b0;
    chk("pt_exit_pt", 32'(bus_i.in_passthru_mode), 32'd0);
    chk("pt_exit_dup", 32'(bus_i.in_dup_mode), 32'd1);
    chk("pt_exit_occ", 32'(bus_i.occupancy), 32'd1);
    chk("pt_exit_err", 32'(bus_i.err_cause), 32'd0);
    bus_i.queue_pop = 1'b1;
    tick();
    chk("dis_hold_occ", 32'(bus_i.occupancy), 32'd1);
    bus_i.enable = 1'b1;
    tick();
    bus_i.queue_pop = 1'b0;
    chk("last_pop_occ", 32'(bus_i.occupancy), 32'd0);
    chk("last_pop_orig", 32'(bus_i.in_dup_mode), 32'd0);

    // ---- PASSTHRU timeout
    do_reset();
    bus_i.enable = 1'b1;
    bus_i.dup_enable_req = 1'b1;
    tick();
    bus_i.queue_push = 1'b1;
    bus_i.goto_passthru_mode = 1'b1;
    tick();
    bus_i.queue_push = 1'b0;
    bus_i.goto_passthru_mode = 1'b0;
    chk("to_entry", 32'(bus_i.in_passthru_mode), 32'd1);
    chk("to_occ", 32'(bus_i.occupancy), 32'd1);
    repeat (63) tick();
    chk("to_63_err", 32'(bus_i.err_cause), 32'd0);
    tick();
    chk("to_64_err", 32'(bus_i.err_cause), 32'b1000);
    chk("to_64_merr", 32'(bus_i.mode_err), 32'd1);
    chk("to_64_pt", 32'(bus_i.in_passthru_mode), 32'd1);
    repeat (3) tick();
    chk("to_stay_pt", 32'(bus_i.in_passthru_mode), 32'd1);
    bus_i.passthru_done = 1'b1;
    tick();
    bus_i.passthru_done = 1'b0;
    chk("to_exit_dup", 32'(bus_i.in_dup_mode), 32'd1);
    chk("to_err_sticky", 32'(bus_i.err_cause), 32'b1000);

    // ---- illegal operations
    to_dup(2);
    bus_i.queue_push = 1'b1;
    bus_i.queue_pop = 1'b1;
    tick();
    bus_i.queue_push = 1'b0;
    bus_i.queue_pop = 1'b0;
    chk("pushpop_err", 32'(bus_i.err_cause), 32'b0100);
    chk("pushpop_occ", 32'(bus_i.occupancy), 32'd2);
    chk("pushpop_dup", 32'(bus_i.in_dup_mode), 32'd1);
    do_reset();
    bus_i.enable = 1'b1;
    bus_i.dup_enable_req = 1'b1;
    tick();
    bus_i.queue_pop = 1'b1;
    tick();
    bus_i.queue_pop = 1'b0;
    chk("pop_orig_err", 32'(bus_i.err_cause), 32'b0100);
    chk("pop_orig_occ", 32'(bus_i.occupancy), 32'd0);

    // ---- asynchronous reset mid-DUP with occupancy 5
    to_dup(5);
    chk("ar_pre_occ", 32'(bus_i.occupancy), 32'd5);
    chk("ar_pre_dup", 32'(bus_i.in_dup_mode), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    clr();
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_idle_after", 32'(bus_i.dup_enable), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
